ahb_to_apb: RTL and testbench
=============================

AHB_TO_APB -- requirements
Module: ahb_to_apb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, for address width.
REQ-002 SHALL have parameter HBURST_WIDTH, default 3, for burst field width.
REQ-003 SHALL have parameter HPROT_WIDTH, default 4, for protection field width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, for data width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: port hclk_i (in, 1) is the clock, and port hresetn_i (in, 1) is the reset.
REQ-006 SHALL have ports pclk_i (in, 1) and presetn_i (in, 1), which SHALL be tied to the same nets as hclk_i and hresetn_i. The design SHALL not use them internally.
REQ-007 SHALL have ports haddr_i (in, ADDR_WIDTH, address), hburst_i (in, HBURST_WIDTH), hmastlock_i (in, 1), hsel_i (in, 1, slave select) and hprot_i (in, HPROT_WIDTH).
REQ-008 SHALL have ports hsize_i (in, 3), hnonsec_i (in, 1), hexcl_i (in, 1), hmaster_i (in, 1), htrans_i (in, 2), hwdata_i (in, DATA_WIDTH), hwstrb_i (in, DATA_WIDTH/8) and hwrite_i (in, 1).
REQ-009 SHALL have ports hrdata_o (out, DATA_WIDTH), hready_o (out, 1, transfer done / bridge ready), hreadyout_o (out, 1, copy of hready_o), hresp_o (out, 1) and hexokay_o (out, 1).
REQ-010 SHALL have ports paddr_o (out, ADDR_WIDTH), psel_o (out, 1), penabe_o (out, 1, APB PENABLE), pwdata_o (out, DATA_WIDTH), prdata_i (in, DATA_WIDTH) and pready_i (in, 1).

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP and ACCESS, clocked on the rising edge of hclk_i.
REQ-012 SHALL accept a transfer at a rising edge when hsel_i=1, htrans_i is NONSEQ (2'b10) or SEQ (2'b11), and hready_o=1.
REQ-013 SHALL, on accept, latch haddr_i into paddr_o and latch hwrite_i internally.
REQ-014 SHALL ignore IDLE (2'b00) and BUSY (2'b01) transfers, with no APB activity and hready_o remaining 1.
REQ-015 SHALL move IDLE->SETUP on accept; otherwise SHALL remain in IDLE.
REQ-016 SHALL, in SETUP, drive psel_o=1, penabe_o=0 and hready_o=0; SHALL register hwdata_i into pwdata_o on this edge for writes; SHALL always move SETUP->ACCESS after one cycle.
REQ-017 SHALL, in ACCESS, drive psel_o=1 and penabe_o=1, with hready_o=pready_i combinationally.
REQ-018 SHALL stay in ACCESS while pready_i=0, holding paddr_o and pwdata_o stable.
REQ-019 SHALL, in ACCESS with pready_i=1, move to SETUP if a new transfer is accepted on the same edge (back-to-back); otherwise SHALL move to IDLE.
REQ-020 SHALL drive hrdata_o=prdata_i in ACCESS for reads, and 0 otherwise.
REQ-021 SHALL drive psel_o=0 and penabe_o=0 in IDLE.
REQ-022 SHALL hold paddr_o and pwdata_o at their last values while in IDLE.
REQ-023 SHALL drive hresp_o=0 (OKAY) at all times.
REQ-024 SHALL drive hexokay_o=0 at all times; exclusive access is not supported.
REQ-025 SHALL drive hreadyout_o identical to hready_o.
REQ-026 SHALL leave hburst_i, hmastlock_i, hprot_i, hsize_i, hnonsec_i, hexcl_i, hmaster_i and hwstrb_i functionally unused. A burst of N beats SHALL be handled as N independent APB transfers.
REQ-027 SHALL give a minimum latency of 3 cycles per transfer (address phase, SETUP, ACCESS with pready_i=1), i.e. exactly one AHB wait state. Each cycle of pready_i=0 in ACCESS SHALL add one wait state.

Reset
REQ-028 SHALL, on hresetn_i=0, immediately and asynchronously force state=IDLE, psel_o=0, penabe_o=0, paddr_o=0, pwdata_o=0, hrdata_o=0, hready_o=1, hreadyout_o=1, hresp_o=0 and hexokay_o=0.
REQ-029 SHALL abort any transfer in progress on reset mid-transfer (SETUP/ACCESS), with no completion reported.
REQ-030 SHALL resume operation at the first rising edge after hresetn_i deasserts.

Verification
REQ-031 Single write: hsel_i=1, htrans_i=NONSEQ, hwrite_i=1, haddr_i=0x0000_1004, then hwdata_i=0xA5A5_5A5A, pready_i=1 -> next cycle psel_o=1/penabe_o=0/paddr_o=0x1004/hready_o=0; following cycle penabe_o=1, pwdata_o=0xA5A5_5A5A, hready_o=1; then IDLE.
REQ-032 Single read with 2 wait states: haddr_i=0x20, hwrite_i=0, pready_i low for 2 ACCESS cycles then 1 with prdata_i=0xDEAD_BEEF -> hready_o=0 for 3 cycles, hrdata_o=0xDEAD_BEEF when hready_o returns 1.
REQ-033 INCR4 burst: NONSEQ then 3 SEQ beats at 0x100/104/108/10C, pready_i=1 -> four SETUP/ACCESS pairs back-to-back, no IDLE cycle between them, paddr_o following each address.
REQ-034 IDLE/BUSY/hsel_i=0 transfers -> psel_o stays 0 and hready_o stays 1.
REQ-035 Reset asserted during ACCESS -> psel_o, penabe_o and paddr_o go to 0 and hready_o to 1 without a clock edge.
REQ-036 All scenarios -> hresp_o=0 and hexokay_o=0 throughout, and hreadyout_o==hready_o every cycle.

Source files
------------

// File: rtl/ahb_to_apb.sv
// AHB-Lite slave to APB master bridge: each AHB beat becomes one APB SETUP/ACCESS
// transfer, with one AHB wait state minimum plus one per cycle of pready_i low.
module ahb_to_apb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int HPROT_WIDTH  = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    hclk_i,
  input  logic                    hresetn_i,
  input  logic                    pclk_i,
  input  logic                    presetn_i,
  input  logic [ADDR_WIDTH-1:0]   haddr_i,
  input  logic [HBURST_WIDTH-1:0] hburst_i,
  input  logic                    hmastlock_i,
  input  logic                    hsel_i,
  input  logic [HPROT_WIDTH-1:0]  hprot_i,
  input  logic [2:0]              hsize_i,
  input  logic                    hnonsec_i,
  input  logic                    hexcl_i,
  input  logic                    hmaster_i,
  input  logic [1:0]              htrans_i,
  input  logic [DATA_WIDTH-1:0]   hwdata_i,
  input  logic [DATA_WIDTH/8-1:0] hwstrb_i,
  input  logic                    hwrite_i,
  output logic [DATA_WIDTH-1:0]   hrdata_o,
  output logic                    hready_o,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  output logic                    hexokay_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penabe_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    write_q, write_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    accept;

  // Sideband qualifiers and the APB clock/reset aliases carry no function here;
  // bursts are split into independent APB transfers.
  logic unused_inputs;
  assign unused_inputs = ^{pclk_i, presetn_i, hburst_i, hmastlock_i, hprot_i, hsize_i,
                           hnonsec_i, hexcl_i, hmaster_i, hwstrb_i, htrans_i[0]};

  // Ready is low for the whole SETUP cycle, then follows the APB slave in ACCESS.
  always_comb begin
    unique case (state_q)
      ST_SETUP:  hready_o = 1'b0;
      ST_ACCESS: hready_o = pready_i;
      default:   hready_o = 1'b1;
    endcase
  end

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  assign accept = hsel_i && htrans_i[1] && hready_o;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    write_d  = write_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          paddr_d = haddr_i;
          write_d = hwrite_i;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        if (write_q) pwdata_d = hwdata_i;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          if (accept) begin
            state_d = ST_SETUP;
            paddr_d = haddr_i;
            write_d = hwrite_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      write_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      write_q   <= write_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign psel_o      = psel_q;
  assign penabe_o    = penable_q;
  assign hrdata_o    = (penable_q && !write_q) ? prdata_i : '0;
  assign hreadyout_o = hready_o;
  assign hresp_o     = 1'b0;
  assign hexokay_o   = 1'b0;

endmodule

// File: tb/tb_ahb_to_apb.sv
// Randomized AHB master / APB slave bench for ahb_to_apb with a queue-based scoreboard.
module tb_ahb_to_apb;

  logic        hclk_i, hresetn_i;
  logic [31:0] haddr_i, hwdata_i, hrdata_o, paddr_o, pwdata_o, prdata_i;
  logic [2:0]  hburst_i, hsize_i;
  logic [3:0]  hprot_i, hwstrb_i;
  logic [1:0]  htrans_i;
  logic        hmastlock_i, hsel_i, hnonsec_i, hexcl_i, hmaster_i, hwrite_i;
  logic        hready_o, hreadyout_o, hresp_o, hexokay_o, psel_o, penabe_o, pready_i;

  ahb_to_apb dut (
    .hclk_i(hclk_i), .hresetn_i(hresetn_i), .pclk_i(hclk_i), .presetn_i(hresetn_i),
    .haddr_i(haddr_i), .hburst_i(hburst_i), .hmastlock_i(hmastlock_i), .hsel_i(hsel_i),
    .hprot_i(hprot_i), .hsize_i(hsize_i), .hnonsec_i(hnonsec_i), .hexcl_i(hexcl_i),
    .hmaster_i(hmaster_i), .htrans_i(htrans_i), .hwdata_i(hwdata_i), .hwstrb_i(hwstrb_i),
    .hwrite_i(hwrite_i), .hrdata_o(hrdata_o), .hready_o(hready_o),
    .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .hexokay_o(hexokay_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penabe_o(penabe_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } ahb_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          acc_cyc;
  } exp_t;

  ahb_t stim[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  initial begin
    hclk_i = 1'b0;
    forever #5 hclk_i = ~hclk_i;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB slave read contents: a fixed address-derived pattern.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h20) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic ahb_t mk(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                              input logic w, input logic [31:0] d);
    ahb_t t;
    t.sel = sel; t.trans = tr; t.addr = a; t.write = w; t.wdata = d;
    return t;
  endfunction

  task automatic gen_random(input int groups);
    for (int g = 0; g < groups; g++) begin
      int kind;
      logic [31:0] base;
      kind = int'($urandom_range(0, 3));
      base = {$urandom_range(0, 255), 2'b00} << 4;
      case (kind)
        0: begin
          int len;
          logic w;
          len = int'($urandom_range(1, 4));
          w = 1'($urandom());
          for (int b = 0; b < len; b++) begin
            if (b > 0 && $urandom_range(0, 3) == 0)
              stim.push_back(mk(1'b1, 2'b01, base + 32'(4 * b), w, $urandom()));
            stim.push_back(mk(1'b1, (b == 0) ? 2'b10 : 2'b11, base + 32'(4 * b), w, $urandom()));
          end
        end
        1: stim.push_back(mk(1'b1, 2'b10, base, 1'($urandom()), $urandom()));
        2: stim.push_back(mk(1'b1, 2'($urandom_range(0, 1)), base, 1'($urandom()), $urandom()));
        default: stim.push_back(mk(1'b0, 2'($urandom_range(2, 3)), base, 1'($urandom()), $urandom()));
      endcase
    end
  endtask

  // AHB master and APB slave: inputs change on the falling edge, hready sampled just before rise.
  task automatic run_stim();
    ahb_t cur, dp;
    bit   dp_v;
    int   budget;
    cur = mk(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    dp = cur;
    dp_v = 0;
    budget = 0;
    while ((stim.size() > 0 || (cur.sel && cur.trans[1]) || dp_v) && budget < 20000) begin
      @(negedge hclk_i);
      cyc++;
      budget++;
      hsel_i = cur.sel; htrans_i = cur.trans; haddr_i = cur.addr; hwrite_i = cur.write;
      hwdata_i = dp_v ? dp.wdata : $urandom();
      hburst_i = 3'($urandom()); hprot_i = 4'($urandom()); hsize_i = 3'($urandom());
      hwstrb_i = 4'($urandom()); hmastlock_i = 1'($urandom()); hnonsec_i = 1'($urandom());
      hexcl_i = 1'($urandom()); hmaster_i = 1'($urandom());
      pready_i = ($urandom_range(0, 2) != 0);
      prdata_i = rom(paddr_o);
      #3;
      if (hready_o) begin
        dp_v = 0;
        if (cur.sel && cur.trans[1]) begin
          exp_t e;
          e.addr = cur.addr; e.write = cur.write; e.wdata = cur.wdata; e.acc_cyc = cyc;
          exp_q.push_back(e);
          dp = cur;
          dp_v = 1;
        end
        cur = (stim.size() > 0) ? stim.pop_front() : mk(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
      end
    end
    if (budget >= 20000) check("stim_timeout", 64'd1, 64'd0);
    hsel_i = 1'b0; htrans_i = 2'b00;
  endtask

  // Monitor: protocol rules every cycle, scoreboard pop on each APB completion.
  initial begin
    bit          prev_setup, prev_wait, c_apb;
    logic [31:0] prev_addr, prev_wdata;
    int          waits;
    exp_t        e;
    prev_setup = 0; prev_wait = 0; waits = 0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge hclk_i);
      #2;
      if (!mon_en) begin
        prev_setup = 0; prev_wait = 0; waits = 0;
      end else begin
        c_apb = psel_o && penabe_o;
        check("hresp", 64'(hresp_o), 64'd0);
        check("hexokay", 64'(hexokay_o), 64'd0);
        check("hreadyout_eq_hready", 64'(hreadyout_o), 64'(hready_o));
        check("hready", 64'(hready_o),
              (psel_o && !penabe_o) ? 64'd0 : c_apb ? 64'(pready_i) : 64'd1);
        check("psel_without_request", 64'(psel_o && exp_q.size() == 0), 64'd0);
        check("penable_without_psel", 64'(penabe_o && !psel_o), 64'd0);
        if (prev_setup || prev_wait) begin
          check("access_follows", 64'(c_apb), 64'd1);
          check("paddr_stable", 64'(paddr_o), 64'(prev_addr));
        end
        if (prev_wait) check("pwdata_stable", 64'(pwdata_o), 64'(prev_wdata));
        if (c_apb && pready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("paddr", 64'(paddr_o), 64'(e.addr));
            if (e.write) begin
              check("pwdata", 64'(pwdata_o), 64'(e.wdata));
              check("hrdata_on_write", 64'(hrdata_o), 64'd0);
            end else begin
              check("hrdata", 64'(hrdata_o), 64'(rom(e.addr)));
            end
            check("latency", 64'(cyc - e.acc_cyc), 64'(2 + waits));
          end
          waits = 0;
        end else if (c_apb) begin
          waits++;
        end
        if (!c_apb) check("hrdata_idle", 64'(hrdata_o), 64'd0);
        prev_setup = psel_o && !penabe_o;
        prev_wait = c_apb && !pready_i;
        prev_addr = paddr_o;
        prev_wdata = pwdata_o;
      end
    end
  end

  initial begin
    hresetn_i = 1'b0;
    hsel_i = 1'b0; htrans_i = 2'b00; haddr_i = '0; hwrite_i = 1'b0; hwdata_i = '0;
    hburst_i = '0; hprot_i = '0; hsize_i = '0; hwstrb_i = '0; hmastlock_i = 1'b0;
    hnonsec_i = 1'b0; hexcl_i = 1'b0; hmaster_i = 1'b0;
    pready_i = 1'b1; prdata_i = 32'hCAFE_F00D;
    #3;
    check("rst_psel", 64'(psel_o), 64'd0);
    check("rst_penable", 64'(penabe_o), 64'd0);
    check("rst_paddr", 64'(paddr_o), 64'd0);
    check("rst_pwdata", 64'(pwdata_o), 64'd0);
    check("rst_hrdata", 64'(hrdata_o), 64'd0);
    check("rst_hready", 64'(hready_o), 64'd1);
    check("rst_hreadyout", 64'(hreadyout_o), 64'd1);
    check("rst_hresp", 64'(hresp_o), 64'd0);
    check("rst_hexokay", 64'(hexokay_o), 64'd0);
    @(negedge hclk_i);
    hresetn_i = 1'b1;
    mon_en = 1;

    // Directed opening: single write, single read, INCR4 write burst, ignored transfers.
    stim.push_back(mk(1'b1, 2'b10, 32'h0000_1004, 1'b1, 32'hA5A5_5A5A));
    stim.push_back(mk(1'b1, 2'b10, 32'h0000_0020, 1'b0, 32'h0));
    stim.push_back(mk(1'b1, 2'b10, 32'h0000_0100, 1'b1, 32'h1111_0100));
    stim.push_back(mk(1'b1, 2'b11, 32'h0000_0104, 1'b1, 32'h1111_0104));
    stim.push_back(mk(1'b1, 2'b11, 32'h0000_0108, 1'b1, 32'h1111_0108));
    stim.push_back(mk(1'b1, 2'b11, 32'h0000_010C, 1'b1, 32'h1111_010C));
    stim.push_back(mk(1'b1, 2'b00, 32'h0000_0200, 1'b1, 32'h0));
    stim.push_back(mk(1'b1, 2'b01, 32'h0000_0204, 1'b0, 32'h0));
    stim.push_back(mk(1'b0, 2'b10, 32'h0000_0208, 1'b1, 32'h0));
    gen_random(120);
    run_stim();
    repeat (4) @(negedge hclk_i);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a stalled ACCESS.
    mon_en = 0;
    @(negedge hclk_i);
    hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0000_3000; hwrite_i = 1'b1; pready_i = 1'b0;
    @(negedge hclk_i);
    hsel_i = 1'b0; htrans_i = 2'b00; hwdata_i = 32'h1111_2222;
    @(negedge hclk_i);
    #2;
    check("pre_rst_access", 64'({psel_o, penabe_o}), 64'd3);
    hresetn_i = 1'b0;
    #1;
    check("midrst_psel", 64'(psel_o), 64'd0);
    check("midrst_penable", 64'(penabe_o), 64'd0);
    check("midrst_paddr", 64'(paddr_o), 64'd0);
    check("midrst_pwdata", 64'(pwdata_o), 64'd0);
    check("midrst_hready", 64'(hready_o), 64'd1);
    check("midrst_hreadyout", 64'(hreadyout_o), 64'd1);
    @(negedge hclk_i);
    hresetn_i = 1'b1;
    pready_i = 1'b1;
    mon_en = 1;
    repeat (3) @(negedge hclk_i);

    // Resume after reset: the aborted write never completes; new transfers run normally.
    stim.push_back(mk(1'b1, 2'b10, 32'h0000_0040, 1'b0, 32'h0));
    stim.push_back(mk(1'b1, 2'b10, 32'h0000_0044, 1'b1, 32'h7777_8888));
    run_stim();
    repeat (4) @(negedge hclk_i);
    check("scoreboard_drained_post_rst", 64'(exp_q.size()), 64'd0);
    mon_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
